// File: rtl/power_trigger.sv
// Power-threshold packet detector: skips a configurable number of samples, then
// raises trigger on |I| > power_thres and drops it after window_size quiet samples.
// Define POWER_TRIGGER_HYST_EN to use power_thres >> 1 as the packet-end threshold.
module power_trigger #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [31:0]          sample_in,
    input  logic                 sample_in_strobe,
    input  logic [15:0]          power_thres,
    input  logic [CNT_WIDTH-1:0] window_size,
    input  logic [31:0]          num_sample_to_skip,
    input  logic                 num_sample_changed,
    output logic [31:0]          sample_out,
    output logic                 sample_out_strobe,
    output logic                 trigger,
    output logic [1:0]           state_dbg
);

    // Handshake: a sample is taken only on a cycle where enable && sample_in_strobe;
    // there is no back-pressure, and sample_out_strobe marks each taken sample one cycle later.
    typedef enum logic [1:0] {
        S_SKIP   = 2'd0,
        S_IDLE   = 2'd1,
        S_PACKET = 2'd2
    } state_t;

    state_t               state;
    logic [31:0]          skip_count;
    logic [CNT_WIDTH-1:0] low_count;

    logic                 acted;
    logic [15:0]          i_val;
    logic [15:0]          i_neg;
    logic [15:0]          abs_i;
    logic [15:0]          low_thres;
    logic [CNT_WIDTH-1:0] window_eff;
    logic [CNT_WIDTH-1:0] low_next;
    logic [32:0]          skip_next;

    always_comb begin
        acted = enable & sample_in_strobe;
        i_val = sample_in[31:16];
        i_neg = ~i_val + 16'd1;
        // -32768 has no positive counterpart, so it saturates to 32767
        if (i_val == 16'h8000)
            abs_i = 16'h7fff;
        else if (i_val[15])
            abs_i = i_neg;
        else
            abs_i = i_val;
`ifdef POWER_TRIGGER_HYST_EN
        low_thres = power_thres >> 1;
`else
        low_thres = power_thres;
`endif
        window_eff = (window_size == '0) ? CNT_WIDTH'(1) : window_size;
        low_next   = (low_count == '1) ? low_count : low_count + CNT_WIDTH'(1);
        skip_next  = {1'b0, skip_count} + 33'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= S_SKIP;
            skip_count        <= '0;
            low_count         <= '0;
            trigger           <= 1'b0;
            sample_out        <= '0;
            sample_out_strobe <= 1'b0;
        end else begin
            sample_out_strobe <= acted;
            if (acted)
                sample_out <= sample_in;

            if (num_sample_changed) begin
                state      <= S_SKIP;
                skip_count <= '0;
                low_count  <= '0;
                trigger    <= 1'b0;
            end else begin
                case (state)
                    S_SKIP: begin
                        // A zero (or already met) skip target leaves on any enabled cycle
                        if (enable && (skip_count >= num_sample_to_skip)) begin
                            state <= S_IDLE;
                        end else if (acted) begin
                            skip_count <= skip_next[31:0];
                            if (skip_next >= {1'b0, num_sample_to_skip})
                                state <= S_IDLE;
                        end
                    end
                    S_IDLE: begin
                        if (acted && (abs_i > power_thres)) begin
                            state     <= S_PACKET;
                            trigger   <= 1'b1;
                            low_count <= '0;
                        end
                    end
                    S_PACKET: begin
                        if (acted) begin
                            if (abs_i < low_thres) begin
                                if (low_next >= window_eff) begin
                                    state     <= S_IDLE;
                                    trigger   <= 1'b0;
                                    low_count <= '0;
                                end else begin
                                    low_count <= low_next;
                                end
                            end else begin
                                low_count <= '0;
                            end
                        end
                    end
                    default: begin
                        state   <= S_SKIP;
                        trigger <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign state_dbg = state;

endmodule

// File: doc/power_trigger.md
POWER_TRIGGER -- requirements
Module: power_trigger

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 16, width of the low-power run counter and of window_size.
REQ-002 SHALL have port clock, input, 1, sole clock; all logic on rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous, active-high.
REQ-004 SHALL have port enable, input, 1, global advance qualifier.
REQ-005 SHALL have port sample_in, input, 32, {I[31:16], Q[15:0]}, both two's complement.
REQ-006 SHALL have port sample_in_strobe, input, 1, sample_in valid.
REQ-007 SHALL have port power_thres, input, 16, unsigned threshold on |I|.
REQ-008 SHALL have port window_size, input, CNT_WIDTH, number of consecutive low samples that ends a packet.
REQ-009 SHALL have port num_sample_to_skip, input, 32, number of strobed samples ignored after start.
REQ-010 SHALL have port num_sample_changed, input, 1, one-cycle pulse that restarts the skip phase.
REQ-011 SHALL have port sample_out, output, 32, registered copy of sample_in for the short-preamble sync stage.
REQ-012 SHALL have port sample_out_strobe, output, 1, registered sample_in_strobe & enable.
REQ-013 SHALL have port trigger, output, 1, high while a packet is considered present.

Function
REQ-014 SHALL compute abs_i = |I|, saturating I = -32768 to 32767, and compare it as unsigned 16-bit.
REQ-015 SHALL implement states S_SKIP, S_IDLE and S_PACKET.
REQ-016 SHALL act on a sample only when enable and sample_in_strobe are both high; otherwise state, counters and trigger hold.
REQ-017 In S_SKIP, SHALL increment skip_count per acted sample and move to S_IDLE on the cycle skip_count reaches num_sample_to_skip; num_sample_to_skip = 0 SHALL move to S_IDLE on the first enabled cycle.
REQ-018 In S_IDLE, an acted sample with abs_i > power_thres SHALL move to S_PACKET and set trigger, clear low_count.
REQ-019 In S_PACKET, an acted sample with abs_i < low_thres SHALL increment low_count (saturating), and any other acted sample SHALL clear it.
REQ-020 When low_count reaches window_size, SHALL clear trigger and move to S_IDLE in the same cycle.
REQ-021 window_size = 0 SHALL be treated as 1.
REQ-022 sample_out/sample_out_strobe SHALL have exactly 1 cycle latency; trigger SHALL change in the same cycle that sample_out_strobe presents the deciding sample.
REQ-023 sample_out SHALL update only on acted samples; sample_out_strobe SHALL be 0 when enable is low.
REQ-024 num_sample_changed SHALL, from any state, clear trigger, skip_count and low_count and enter S_SKIP; a coincident sample SHALL not be counted, but SHALL still pass to sample_out.
REQ-025 trigger SHALL be 0 in S_SKIP and S_IDLE, and 1 in S_PACKET.

Reset
REQ-026 reset SHALL take priority over enable and num_sample_changed.
REQ-027 reset SHALL force S_SKIP, skip_count = 0, low_count = 0, trigger = 0, sample_out = 0 and sample_out_strobe = 0 on the next edge.
REQ-028 Reset asserted mid-packet SHALL drop trigger on the next edge, and the skip phase SHALL rerun afterwards.

Configuration
REQ-029 Macro POWER_TRIGGER_HYST_EN defined: low_thres SHALL be power_thres >> 1, giving hysteresis.
REQ-030 Macro not defined: low_thres SHALL be power_thres, with no other behavioural difference.

Verification
REQ-031 Skip phase: skip = 4, thres = 100, first 6 samples with I = 500 -> trigger rises with sample_out of the 5th sample.
REQ-032 Packet end: window = 3, thres = 100, packet active, I sequence 50, 50, 200, 50, 50, 50 -> trigger falls with sample_out of the 6th sample.
REQ-033 Hysteresis: thres = 100, window = 1, packet active, I = 70 -> with POWER_TRIGGER_HYST_EN trigger stays 1; without it trigger falls.
REQ-034 Saturation: I = -32768, thres = 32766 in S_IDLE -> trigger = 1; I = 100 with thres = 100 -> no trigger (strict >).
REQ-035 Restart mid-packet: num_sample_changed pulse with skip = 2 while trigger = 1 -> trigger = 0 next cycle, and the next 2 strobed samples are ignored even with I = 1000.
REQ-036 Enable gap: enable low for 5 cycles with strobes high in S_PACKET -> sample_out_strobe = 0, and low_count and trigger unchanged.
